// File: rtl/gb_dbg_pkg.sv
//==============================================================================
// Module      : gb_dbg_pkg
// Description : Shared trace-entry layout, widths and capture-state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package gb_dbg_pkg;

    localparam int TRACE_W = 96;

    localparam int PC_LSB = 80;
    localparam int SP_LSB = 64;
    localparam int AF_LSB = 48;
    localparam int BC_LSB = 32;
    localparam int DE_LSB = 16;
    localparam int HL_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } trace_state_t;

    function automatic logic [TRACE_W-1:0] pack_entry(
        input logic [15:0] pc,
        input logic [15:0] sp,
        input logic [15:0] af,
        input logic [15:0] bc,
        input logic [15:0] de,
        input logic [15:0] hl
    );
        logic [TRACE_W-1:0] e;
        e               = '0;
        e[PC_LSB +: 16] = pc;
        e[SP_LSB +: 16] = sp;
        e[AF_LSB +: 16] = af;
        e[BC_LSB +: 16] = bc;
        e[DE_LSB +: 16] = de;
        e[HL_LSB +: 16] = hl;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
//==============================================================================
// Module      : trace_fifo
// Description : Circular entry store with optional overwrite-oldest when full.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 96,
    parameter bit WRAP  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_pop;
    logic w_overwrite;
    logic w_do_write;
    logic w_adv_rd;

    assign full  = (r_count == C_DEPTH);
    assign empty = (r_count == '0);
    assign count = r_count;

    assign w_do_pop    = pop && !empty && !clear;
    assign w_overwrite = push && full && !w_do_pop && !clear;
    // A full push still writes when a pop frees the slot or when overwriting.
    assign w_do_write  = push && !clear && (!full || w_do_pop || WRAP);
    assign w_adv_rd    = w_do_pop || (w_overwrite && WRAP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_adv_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_write && !w_adv_rd) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_adv_rd && !w_do_write) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign rd_data = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/dbg_trace_buffer.sv
//==============================================================================
// Module      : dbg_trace_buffer
// Description : Retired-instruction register trace buffer with arm/freeze.
//               Optional PC window filter enabled by macro TRACE_FILTER_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dbg_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter int WRAP         = 1,
    parameter int STOP_ON_HALT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              dbg_pc,
    input  logic [15:0]              dbg_sp,
    input  logic [15:0]              dbg_AF,
    input  logic [15:0]              dbg_BC,
    input  logic [15:0]              dbg_DE,
    input  logic [15:0]              dbg_HL,
    input  logic                     dbg_instruction_retired,
    input  logic                     dbg_halted,
`ifdef TRACE_FILTER_EN
    input  logic [15:0]              pc_lo,
    input  logic [15:0]              pc_hi,
`endif
    input  logic                     arm,
    output logic                     rd_valid,
    output logic [95:0]              rd_data,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              overflow_cnt,
    output logic                     frozen
);

    import gb_dbg_pkg::*;

    trace_state_t r_state;
    trace_state_t w_state_nxt;

    logic          r_retired_prev;
    logic [15:0]   r_overflow_cnt;

    logic w_event;
    logic w_capturing;
    logic w_in_range;
    logic w_push;
    logic w_pop;
    logic w_halt;
    logic w_full;
    logic w_empty;
    logic w_overflow;

    assign w_event     = dbg_instruction_retired && !r_retired_prev;
    assign w_capturing = (r_state == ST_CAPTURE) && !arm;

`ifdef TRACE_FILTER_EN
    assign w_in_range = (dbg_pc >= pc_lo) && (dbg_pc <= pc_hi);
`else
    assign w_in_range = 1'b1;
`endif

    assign w_push     = w_capturing && w_event && w_in_range;
    assign w_pop      = rd_valid && rd_ready && !arm;
    assign w_halt     = w_capturing && w_event && dbg_halted && (STOP_ON_HALT != 0);
    // Overflow only when a stored entry cannot simply replace a popped one.
    assign w_overflow = w_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_retired_prev <= 1'b0;
            r_overflow_cnt <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_retired_prev <= dbg_instruction_retired;
            if (arm) begin
                r_overflow_cnt <= '0;
            end else if (w_overflow && (r_overflow_cnt != 16'hFFFF)) begin
                r_overflow_cnt <= r_overflow_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (arm) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (arm) w_state_nxt = ST_CAPTURE;
                        else if (w_halt) w_state_nxt = ST_FROZEN;
            ST_FROZEN:  if (arm) w_state_nxt = ST_CAPTURE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRACE_W),
        .WRAP  (WRAP != 0)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_push),
        .pop     (w_pop),
        .clear   (arm),
        .wr_data (pack_entry(dbg_pc, dbg_sp, dbg_AF, dbg_BC, dbg_DE, dbg_HL)),
        .rd_data (rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (count)
    );

    assign rd_valid     = !w_empty;
    assign overflow_cnt = r_overflow_cnt;
    assign frozen       = (r_state == ST_FROZEN);

endmodule

`default_nettype wire

// File: tb/tb_dbg_trace_buffer.sv
//==============================================================================
// Module      : tb_dbg_trace_buffer
// Description : Self-checking bench for dbg_trace_buffer (WRAP=1 and WRAP=0
//               instances side by side, DEPTH=4). Honors TRACE_FILTER_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dbg_trace_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, arm, retired, halted, rd_ready;
    logic [15:0] pc, sp, af, bc, de, hl;
`ifdef TRACE_FILTER_EN
    logic [15:0] pc_lo, pc_hi;
`endif

    logic          rd_valid_w, rd_valid_n, frozen_w, frozen_n;
    logic [95:0]   rd_data_w, rd_data_n;
    logic [CW-1:0] count_w, count_n;
    logic [15:0]   ovf_w, ovf_n;

    dbg_trace_buffer #(.DEPTH(DEPTH), .WRAP(1), .STOP_ON_HALT(1)) u_dut_w (
        .clk(clk), .reset(reset), .dbg_pc(pc), .dbg_sp(sp), .dbg_AF(af),
        .dbg_BC(bc), .dbg_DE(de), .dbg_HL(hl),
        .dbg_instruction_retired(retired), .dbg_halted(halted),
`ifdef TRACE_FILTER_EN
        .pc_lo(pc_lo), .pc_hi(pc_hi),
`endif
        .arm(arm), .rd_valid(rd_valid_w), .rd_data(rd_data_w), .rd_ready(rd_ready),
        .count(count_w), .overflow_cnt(ovf_w), .frozen(frozen_w)
    );

    dbg_trace_buffer #(.DEPTH(DEPTH), .WRAP(0), .STOP_ON_HALT(1)) u_dut_n (
        .clk(clk), .reset(reset), .dbg_pc(pc), .dbg_sp(sp), .dbg_AF(af),
        .dbg_BC(bc), .dbg_DE(de), .dbg_HL(hl),
        .dbg_instruction_retired(retired), .dbg_halted(halted),
`ifdef TRACE_FILTER_EN
        .pc_lo(pc_lo), .pc_hi(pc_hi),
`endif
        .arm(arm), .rd_valid(rd_valid_n), .rd_data(rd_data_n), .rd_ready(rd_ready),
        .count(count_n), .overflow_cnt(ovf_n), .frozen(frozen_n)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 idle, 1 capture, 2 frozen; one queue per instance.
    int          m_state = 0;
    logic [95:0] sb_w[$];
    logic [95:0] sb_n[$];
    int          m_ovf_w = 0;
    int          m_ovf_n = 0;

    typedef struct {
        logic [15:0] pc;
        int          exp_count;
        int          exp_ovf_w;
        int          exp_ovf_n;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pass_filter(input logic [15:0] p);
`ifdef TRACE_FILTER_EN
        return (p >= pc_lo) && (p <= pc_hi);
`else
        return (p == p);
`endif
    endfunction

    task automatic set_regs(input logic [15:0] p, output logic [95:0] e);
        pc = p;
        sp = p + 16'h1000;
        af = p ^ 16'h00FF;
        bc = ~p;
        de = {p[7:0], p[15:8]};
        hl = p + 16'h0042;
        e  = {pc, sp, af, bc, de, hl};
    endtask

    task automatic model_event(input logic [95:0] e, input logic [15:0] p,
                               input logic h, input logic popping);
        if (popping && sb_w.size() != 0) begin
            void'(sb_w.pop_front());
            void'(sb_n.pop_front());
        end
        if (m_state == 1) begin
            if (pass_filter(p)) begin
                if (sb_w.size() == DEPTH) begin
                    void'(sb_w.pop_front());
                    if (m_ovf_w < 65535) m_ovf_w++;
                end
                sb_w.push_back(e);
                if (sb_n.size() == DEPTH) begin
                    if (m_ovf_n < 65535) m_ovf_n++;
                end else begin
                    sb_n.push_back(e);
                end
            end
            if (h) m_state = 2;
        end
    endtask

    task automatic peek(input string name);
        chk({name, " rd_valid_w"}, 96'(rd_valid_w), 96'(sb_w.size() != 0));
        chk({name, " rd_valid_n"}, 96'(rd_valid_n), 96'(sb_n.size() != 0));
        if (sb_w.size() != 0) chk({name, " rd_data_w"}, rd_data_w, sb_w[0]);
        if (sb_n.size() != 0) chk({name, " rd_data_n"}, rd_data_n, sb_n[0]);
    endtask

    task automatic read_one(input string name);
        peek(name);
        rd_ready = 1'b1;
        if (sb_w.size() != 0) begin
            void'(sb_w.pop_front());
            void'(sb_n.pop_front());
        end
        cycle();
        rd_ready = 1'b0;
    endtask

    task automatic pulse(input logic [15:0] p, input logic h, input logic rdy);
        logic [95:0] e;
        set_regs(p, e);
        halted   = h;
        retired  = 1'b1;
        rd_ready = rdy;
        if (rdy) peek("pop_during_push");
        model_event(e, p, h, rdy);
        cycle();
        retired  = 1'b0;
        halted   = 1'b0;
        rd_ready = 1'b0;
        cycle();
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        sb_w.delete();
        sb_n.delete();
        m_ovf_w = 0;
        m_ovf_n = 0;
        m_state = 1;
    endtask

    task automatic chk_status(input string name);
        chk({name, " count_w"},  96'(count_w),  96'(sb_w.size()));
        chk({name, " count_n"},  96'(count_n),  96'(sb_n.size()));
        chk({name, " ovf_w"},    96'(ovf_w),    96'(m_ovf_w));
        chk({name, " ovf_n"},    96'(ovf_n),    96'(m_ovf_n));
        chk({name, " frozen_w"}, 96'(frozen_w), 96'(m_state == 2));
        chk({name, " frozen_n"}, 96'(frozen_n), 96'(m_state == 2));
    endtask

    initial begin
        logic [95:0] e;
        vecs[0] = '{16'h0001, 1, 0, 0};
        vecs[1] = '{16'h0002, 2, 0, 0};
        vecs[2] = '{16'h0003, 3, 0, 0};
        vecs[3] = '{16'h0004, 4, 0, 0};
        vecs[4] = '{16'h0005, 4, 1, 1};
        vecs[5] = '{16'h0006, 4, 2, 2};

        reset = 1'b1; arm = 1'b0; retired = 1'b0; halted = 1'b0; rd_ready = 1'b0;
        pc = '0; sp = '0; af = '0; bc = '0; de = '0; hl = '0;
`ifdef TRACE_FILTER_EN
        pc_lo = 16'h0000; pc_hi = 16'hFFFF;
`endif
        cycle();
        cycle();
        chk("reset rd_valid_w", 96'(rd_valid_w), 96'(0));
        chk_status("reset");
        reset = 1'b0;
        cycle();

        // Events in IDLE are ignored.
        pulse(16'h0050, 1'b0, 1'b0);
        chk_status("idle_ignore");

        // Basic in-order capture and readout.
        do_arm();
        pulse(16'h0100, 1'b0, 1'b0);
        pulse(16'h0101, 1'b0, 1'b0);
        pulse(16'h0102, 1'b0, 1'b0);
        chk_status("basic3");
        for (int i = 0; i < 3; i++) read_one("basic_read");
        peek("basic_empty");

        // Retired held high several cycles yields a single entry.
        set_regs(16'h0111, e);
        retired = 1'b1;
        model_event(e, 16'h0111, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle();
        retired = 1'b0;
        cycle();
        chk_status("held_high");
        read_one("held_read");

        // Overflow table: WRAP=1 keeps newest, WRAP=0 keeps oldest.
        do_arm();
        for (int i = 0; i < 6; i++) begin
            pulse(vecs[i].pc, 1'b0, 1'b0);
            chk("tbl count_w", 96'(count_w), 96'(vecs[i].exp_count));
            chk("tbl count_n", 96'(count_n), 96'(vecs[i].exp_count));
            chk("tbl ovf_w",   96'(ovf_w),   96'(vecs[i].exp_ovf_w));
            chk("tbl ovf_n",   96'(ovf_n),   96'(vecs[i].exp_ovf_n));
        end
        chk("wrap oldest pc_w", 96'(rd_data_w[95:80]), 96'(16'h0003));
        chk("nowrap oldest pc_n", 96'(rd_data_n[95:80]), 96'(16'h0001));
        for (int i = 0; i < 3; i++) read_one("ovf_read");

        // Arm coincident with event and pop: arm wins.
        set_regs(16'h0777, e);
        arm = 1'b1; retired = 1'b1; rd_ready = 1'b1;
        cycle();
        arm = 1'b0; retired = 1'b0; rd_ready = 1'b0;
        sb_w.delete(); sb_n.delete(); m_ovf_w = 0; m_ovf_n = 0; m_state = 1;
        cycle();
        chk_status("arm_wins");
        peek("arm_wins");

        // Full with simultaneous pop: no overflow, count unchanged.
        for (int i = 0; i < 4; i++) pulse(16'h0021 + 16'(i), 1'b0, 1'b0);
        pulse(16'h0025, 1'b0, 1'b1);
        chk_status("full_pushpop");
        for (int i = 0; i < 4; i++) read_one("full_pushpop_read");

        // Halt freezes after storing; reads allowed while frozen; arm restarts.
        do_arm();
        pulse(16'h0400, 1'b0, 1'b0);
        pulse(16'h0401, 1'b1, 1'b0);
        chk_status("halt");
        pulse(16'h0402, 1'b0, 1'b0);
        chk_status("frozen_ignore");
        read_one("frozen_read");
        do_arm();
        chk_status("rearm");

`ifdef TRACE_FILTER_EN
        pc_lo = 16'h0200; pc_hi = 16'h02FF;
        pulse(16'h01FF, 1'b0, 1'b0);
        pulse(16'h0200, 1'b0, 1'b0);
        pulse(16'h02FF, 1'b0, 1'b0);
        pulse(16'h0300, 1'b0, 1'b0);
        chk_status("filter");
        read_one("filter_read");
        read_one("filter_read");
        pulse(16'h0100, 1'b1, 1'b0);
        chk_status("filter_halt");
        pc_lo = 16'h0000; pc_hi = 16'hFFFF;
        do_arm();
`endif

        // Asynchronous reset mid-stream clears everything without a clock edge.
        for (int i = 0; i < 6; i++) pulse(16'h0031 + 16'(i), 1'b0, 1'b0);
        pulse(16'h0037, 1'b1, 1'b0);
        chk_status("pre_reset");
        #2;
        reset = 1'b1;
        #1;
        sb_w.delete(); sb_n.delete(); m_ovf_w = 0; m_ovf_n = 0; m_state = 0;
        chk_status("async_reset");
        peek("async_reset");
        cycle();
        reset = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dbg_trace_buffer.md
DBG_TRACE_BUFFER -- requirements
Module: dbg_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, entry count; SHALL be a power of two and at least 2.
REQ-002 Parameter WRAP, default 1; 1 = overwrite oldest when full, 0 = drop newest when full.
REQ-003 Parameter STOP_ON_HALT, default 1; 1 = freeze capture after storing the halted instruction.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 dbg_pc, dbg_sp, dbg_AF, dbg_BC, dbg_DE, dbg_HL  in  16 each  CPU register snapshot.
REQ-007 dbg_instruction_retired  in  1  level, rising edge marks one retired instruction.
REQ-008 dbg_halted  in  1  CPU halted flag, sampled with the snapshot.
REQ-009 arm  in  1  single-cycle pulse; clears buffer, starts capture.
REQ-010 rd_valid  out  1  buffer non-empty; rd_data  out  96  oldest entry; rd_ready  in  1  consumer accepts.
REQ-011 count  out  $clog2(DEPTH)+1  entries held; overflow_cnt  out  16  lost entries; frozen  out  1  state is FROZEN.

Function
REQ-012 Capture event SHALL be detected as dbg_instruction_retired high while its registered previous value is low.
REQ-013 States SHALL be IDLE, CAPTURE, FROZEN; captures occur only in CAPTURE.
REQ-014 IDLE or FROZEN + arm -> CAPTURE; CAPTURE + arm -> CAPTURE with buffer cleared.
REQ-015 CAPTURE + event with dbg_halted=1 and STOP_ON_HALT=1 -> entry stored, then FROZEN next cycle.
REQ-016 Entry layout SHALL be {pc[95:80], sp, AF, BC, DE, HL[15:0]}, values sampled on the detecting edge.
REQ-017 A stored entry SHALL raise rd_valid and count on the cycle after the detecting edge (latency 1).
REQ-018 rd_valid SHALL equal (count != 0); a pop occurs on rd_valid && rd_ready and advances to the next-oldest entry.
REQ-019 Reads SHALL be allowed in every state, including FROZEN.
REQ-020 Full, push without pop, WRAP=1: oldest overwritten, read pointer advances, count stays DEPTH, overflow_cnt +1.
REQ-021 Full, push without pop, WRAP=0: new entry dropped, contents unchanged, overflow_cnt +1.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and SHALL NOT count as overflow, full or not.
REQ-023 overflow_cnt SHALL saturate at 16'hFFFF.
REQ-024 arm coincident with an event or a pop: arm wins; event discarded, pop ignored, count and overflow_cnt to 0.
REQ-025 Pointers SHALL wrap modulo DEPTH; rd_data stable while rd_valid && !rd_ready, except on a WRAP=1 overwrite.

Reset
REQ-026 reset SHALL force IDLE, pointers 0, count 0, overflow_cnt 0, frozen 0, rd_valid 0, edge-detect register 0.
REQ-027 Reset mid-capture or mid-read SHALL discard all entries; rd_data content is don't-care while rd_valid=0.

Configuration
REQ-028 Macro TRACE_FILTER_EN, when defined, SHALL add inputs pc_lo, pc_hi (16 each).
REQ-029 With it, an event SHALL be stored only if pc_lo <= dbg_pc <= pc_hi (inclusive, unsigned); filtered events never count as overflow.
REQ-030 With it, a filtered-out halted event SHALL still trigger FROZEN per REQ-015, without storing.
REQ-031 Without it, the ports SHALL be absent and every event stored.

Structure
REQ-032 Package gb_dbg_pkg SHALL hold TRACE_W=96, the entry field offsets, and the state enum.
REQ-033 Storage and pointers SHALL be sub-module trace_fifo (DEPTH, WIDTH params, push/pop/clear, full/empty/count).

Verification
REQ-034 arm, 3 retire pulses PC=0100,0101,0102 -> count=3; reads in order 0100,0101,0102; rd_valid then 0.
REQ-035 DEPTH=4 WRAP=1, 6 pulses PC=1..6 no reads -> count=4, overflow_cnt=2, read 3,4,5,6.
REQ-036 DEPTH=4 WRAP=0, same stimulus -> count=4, overflow_cnt=2, read 1,2,3,4.
REQ-037 Retire with dbg_halted=1, STOP_ON_HALT=1 -> entry stored, frozen=1, later pulses ignored; arm -> frozen=0, count=0.
REQ-038 Full, rd_ready=1 during a pulse -> count unchanged, overflow_cnt unchanged; retired held high 5 cycles -> one entry.
REQ-039 TRACE_FILTER_EN, pc_lo=0200 pc_hi=02FF, PCs 01FF,0200,02FF,0300 -> entries 0200,02FF only; async reset mid-stream -> all outputs 0 immediately.
